load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 38 +++
 rtl/load_store_unit.sv | 116 +++++++++++
 tb/tb_load_store_unit.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared decoder definitions: load/store size codes and the helpers that classify them.
package load_store_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_width_e;

    // Size and byte offset remembered from the request cycle for load formatting.
    typedef struct packed {
        logic [2:0] size;
        logic [1:0] offset;
    } ldst_ctx_t;

    // Unknown size codes fall back to a full word access.
    function automatic acc_width_e ldst_width(input logic [2:0] size);
        case (size)
            LDST_B, LDST_BU: return ACC_BYTE;
            LDST_H, LDST_HU: return ACC_HALF;
            default:         return ACC_WORD;
        endcase
    endfunction

    function automatic logic ldst_signed(input logic [2:0] size);
        return (size == LDST_B) || (size == LDST_H);
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory access per two cycles, with byte/half
// lane steering on stores and sign/zero extension on loads.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e     state_q, state_d;
    ldst_ctx_t  ctx_q, ctx_d;
    logic       rsp_valid;
    acc_width_e req_width;
    acc_width_e rsp_width;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ctx_q   <= '0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
        end
    end

    // Handshake: request issues in IDLE, response is consumed in WAIT; reset masks everything.
    always_comb begin
        state_d      = state_q;
        ctx_d        = ctx_q;
        mem_req_o    = 1'b0;
        core_stall_o = 1'b0;
        rsp_valid    = 1'b0;
        if (!rst_i) begin
            case (state_q)
                S_IDLE: begin
                    if (core_req_i) begin
                        mem_req_o    = 1'b1;
                        core_stall_o = 1'b1;
                        ctx_d.size   = core_size_i;
                        ctx_d.offset = core_addr_i[1:0];
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_ready_i) begin
                        rsp_valid = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        core_stall_o = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign mem_we_o   = core_we_i;
    assign mem_addr_o = core_addr_i;

    // Store side: replicate the narrow datum on every lane and enable only the addressed bytes.
    always_comb begin
        req_width = ldst_width(core_size_i);
        mem_be_o  = {BE_W{1'b1}};
        mem_wd_o  = core_wd_i;
        case (req_width)
            ACC_BYTE: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            ACC_HALF: begin
                mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the lane chosen at request time and extend it to a full word.
    always_comb begin
        rsp_width = ldst_width(ctx_q.size);
        rd_byte   = 8'(mem_rd_i >> {ctx_q.offset, 3'b000});
        rd_half   = 16'(mem_rd_i >> {ctx_q.offset[1], 4'b0000});
        core_rd_o = '0;
        if (rsp_valid) begin
            case (rsp_width)
                ACC_BYTE: core_rd_o = ldst_signed(ctx_q.size) ?
                                      {{(XLEN - 8){rd_byte[7]}}, rd_byte} : 32'(rd_byte);
                ACC_HALF: core_rd_o = ldst_signed(ctx_q.size) ?
                                      {{(XLEN - 16){rd_half[15]}}, rd_half} : 32'(rd_half);
                default:  core_rd_o = mem_rd_i;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-addressed reference memory model,
// per-cycle output comparison, randomized traffic plus directed literal checks.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    always #5 clk_i = ~clk_i;

    load_store_unit dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Memory environment seen by the DUT: word array written through the DUT's byte enables.
    logic [31:0] env_mem [16];

    always @(posedge clk_i) begin
        if (mem_req_o) begin
            mem_rd_i <= env_mem[mem_addr_o[5:2]];
            if (mem_we_o) begin
                for (int k = 0; k < 4; k++) begin
                    if (mem_be_o[k]) env_mem[mem_addr_o[5:2]][8*k +: 8] = mem_wd_o[8*k +: 8];
                end
            end
        end
    end

    // Reference: byte-addressed memory updated from the core-side view of each access.
    logic [7:0]  ref_mem [64];
    bit          busy = 1'b0;
    logic [31:0] exp_rd = '0;

    function automatic int nbytes(input logic [2:0] sz);
        if (sz == SZ_B || sz == SZ_BU) return 1;
        if (sz == SZ_H || sz == SZ_HU) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] sz);
        int n = nbytes(sz);
        int base = int'(a[5:0]) - (int'(a[5:0]) % n);
        logic [31:0] v = '0;
        for (int j = 0; j < n; j++) v[8*j +: 8] = ref_mem[base + j];
        if ((sz == SZ_B || sz == SZ_H) && v[8*n - 1]) begin
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        int base = int'(a[5:0]) - (int'(a[5:0]) % n);
        for (int j = 0; j < n; j++) ref_mem[base + j] = wd[8*j +: 8];
    endtask

    function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [1:0] off);
        int n = nbytes(sz);
        logic [3:0] be = '0;
        for (int k = 0; k < 4; k++) be[k] = ((k / n) == (int'(off) / n));
        return be;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        logic [31:0] v = '0;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = wd[8*(k % n) +: 8];
        return v;
    endfunction

    // Model advance at the active edge.
    always @(posedge clk_i) begin
        if (rst_i) begin
            busy = 1'b0;
        end else if (!busy) begin
            if (core_req_i) begin
                busy   = 1'b1;
                exp_rd = ref_load(core_addr_i, core_size_i);
                if (core_we_i) ref_store(core_addr_i, core_size_i, core_wd_i);
            end
        end else if (mem_ready_i) begin
            busy = 1'b0;
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    always @(negedge clk_i) begin
        check("mem_we", 32'(mem_we_o), 32'(core_we_i));
        check("mem_addr", mem_addr_o, core_addr_i);
        if (rst_i) begin
            check("rst_req", 32'(mem_req_o), 32'd0);
            check("rst_stall", 32'(core_stall_o), 32'd0);
            check("rst_rd", core_rd_o, 32'd0);
        end else if (!busy) begin
            check("idle_req", 32'(mem_req_o), 32'(core_req_i));
            check("idle_stall", 32'(core_stall_o), 32'(core_req_i));
            check("idle_rd", core_rd_o, 32'd0);
            if (core_req_i) begin
                check("be", 32'(mem_be_o), 32'(exp_be(core_size_i, core_addr_i[1:0])));
                check("wd", mem_wd_o, exp_wd(core_size_i, core_wd_i));
            end
        end else begin
            check("wait_req", 32'(mem_req_o), 32'd0);
            check("wait_stall", 32'(core_stall_o), 32'(!mem_ready_i));
            check("wait_rd", core_rd_o, mem_ready_i ? exp_rd : 32'd0);
        end
    end

    task automatic do_access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd, input int delay,
                             output logic [31:0] rd, output logic [31:0] be,
                             output logic [31:0] wdo, output int stalls, output int reqs);
        bit done = 1'b0;
        stalls = 0;
        reqs   = 0;
        rd     = '0;
        be     = '0;
        wdo    = '0;
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                @(posedge clk_i); #1;
                mem_ready_i = (c > delay);
            end
            @(negedge clk_i);
            if (core_stall_o) stalls++;
            if (mem_req_o) reqs++;
            if (c == 0) begin
                be  = 32'(mem_be_o);
                wdo = mem_wd_o;
            end else if (!core_stall_o) begin
                rd   = core_rd_o;
                done = 1'b1;
                break;
            end
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
    endtask

    logic [31:0] rd, be, wdo;
    int          stalls, reqs;
    logic [5:0]  mask;

    initial begin
        rst_i       = 1'b1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = SZ_W;
        core_addr_i = 32'h0;
        core_wd_i   = 32'h0;
        mem_ready_i = 1'b0;
        for (int w = 0; w < 16; w++) begin
            env_mem[w] = $urandom;
            for (int k = 0; k < 4; k++) ref_mem[4*w + k] = env_mem[w][8*k +: 8];
        end

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_stall_lit", 32'(core_stall_o), 32'd0);
        check("reset_req_lit", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i      = 1'b0;
        core_req_i = 1'b0;

        // Word store then load
        do_access(1'b1, SZ_W, 32'h10, 32'hDEADBEEF, 0, rd, be, wdo, stalls, reqs);
        check("sw_be", be, 32'hF);
        check("sw_stall", 32'(stalls), 32'd1);
        do_access(1'b0, SZ_W, 32'h10, 32'h0, 0, rd, be, wdo, stalls, reqs);
        check("lw_rd", rd, 32'hDEADBEEF);
        check("lw_be", be, 32'hF);
        check("lw_stall", 32'(stalls), 32'd1);

        // Byte store at offset 3, signed and unsigned reloads
        do_access(1'b1, SZ_B, 32'h13, 32'h000000A5, 0, rd, be, wdo, stalls, reqs);
        check("sb_be", be, 32'h8);
        check("sb_wd", wdo, 32'hA5A5A5A5);
        do_access(1'b0, SZ_B, 32'h13, 32'h0, 0, rd, be, wdo, stalls, reqs);
        check("lb_rd", rd, 32'hFFFFFFA5);
        do_access(1'b0, SZ_BU, 32'h13, 32'h0, 0, rd, be, wdo, stalls, reqs);
        check("lbu_rd", rd, 32'h000000A5);

        // Half store in the upper half, signed and unsigned reloads
        do_access(1'b1, SZ_H, 32'h22, 32'h00008001, 0, rd, be, wdo, stalls, reqs);
        check("sh_be", be, 32'hC);
        check("sh_wd", wdo, 32'h80018001);
        do_access(1'b0, SZ_H, 32'h22, 32'h0, 0, rd, be, wdo, stalls, reqs);
        check("lh_rd", rd, 32'hFFFF8001);
        do_access(1'b0, SZ_HU, 32'h22, 32'h0, 0, rd, be, wdo, stalls, reqs);
        check("lhu_rd", rd, 32'h00008001);

        // Misaligned accesses drop the low address bits
        do_access(1'b0, SZ_W, 32'h13, 32'h0, 0, rd, be, wdo, stalls, reqs);
        check("lw_misaligned", rd, 32'hA5ADBEEF);
        do_access(1'b0, SZ_HU, 32'h23, 32'h0, 0, rd, be, wdo, stalls, reqs);
        check("lhu_misaligned", rd, 32'h00008001);

        // Slow memory: three not-ready cycles
        do_access(1'b0, SZ_W, 32'h10, 32'h0, 3, rd, be, wdo, stalls, reqs);
        check("slow_stall", 32'(stalls), 32'd4);
        check("slow_reqs", 32'(reqs), 32'd1);
        check("slow_rd", rd, 32'hA5ADBEEF);

        // Reset while waiting abandons the access
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = SZ_W;
        core_addr_i = 32'h10;
        mem_ready_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i      = 1'b1;
        core_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_stall", 32'(core_stall_o), 32'd0);
        check("post_rst_req", 32'(mem_req_o), 32'd0);
        do_access(1'b0, SZ_W, 32'h10, 32'h0, 0, rd, be, wdo, stalls, reqs);
        check("post_rst_lw", rd, 32'hA5ADBEEF);

        // Request held for six cycles: issues every other cycle
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = SZ_W;
        core_addr_i = 32'h22;
        mem_ready_i = 1'b1;
        mask = '0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(posedge clk_i); #1;
            end
            @(negedge clk_i);
            mask[c] = mem_req_o;
        end
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        check("b2b_mask", 32'(mask), 32'h15);

        // Randomized traffic, including rare resets and unknown size codes
        for (int i = 0; i < 600; i++) begin
            @(posedge clk_i); #1;
            rst_i       = ($urandom_range(0, 99) == 0);
            mem_ready_i = ($urandom_range(0, 3) != 0);
            if (!busy) begin
                core_req_i  = ($urandom_range(0, 9) < 6);
                core_we_i   = $urandom_range(0, 1) == 1;
                core_size_i = 3'($urandom_range(0, 7));
                core_addr_i = $urandom;
                core_wd_i   = $urandom;
            end
        end
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
